// File: rtl/jam_cost_table_pkg.sv
`default_nettype none
// ============================================================================
// Package  : jam_pkg
// Brief    : Shared widths, state encoding and entry type for the cost table.
// Revision : 1.0
// ============================================================================
package jam_pkg;
    localparam int DW    = 7;
    localparam int N     = 8;
    localparam int AW    = $clog2(N);
    localparam int CW    = DW + 6;
    localparam int DEPTH = N * N;
    localparam int CNTW  = 2 * AW;

    typedef enum logic {LOAD = 1'b0, READY = 1'b1} jam_tbl_state_t;
    typedef logic [DW-1:0] cost_t;
endpackage
`default_nettype wire

// File: rtl/jam_cost_table_if.sv
`default_nettype none
// ============================================================================
// Interface : jam_cost_table_if
// Brief     : Load stream, lookup port and status bundle of the cost table.
// Revision  : 1.0
// ============================================================================
interface jam_cost_table_if;
    import jam_pkg::*;

    logic            in_valid;
    cost_t           in_data;
    logic            in_ready;
    logic            reload;
    logic [AW-1:0]   W;
    logic [AW-1:0]   J;
    cost_t           Cost;
    logic            tbl_ready;
    logic [CW-1:0]   checksum;

    modport master (
        output in_valid, in_data, reload, W, J,
        input  in_ready, Cost, tbl_ready, checksum
    );

    modport slave (
        input  in_valid, in_data, reload, W, J,
        output in_ready, Cost, tbl_ready, checksum
    );
endinterface
`default_nettype wire

// File: rtl/jam_cost_table_mem.sv
`default_nettype none
// ============================================================================
// Module   : jam_cost_mem
// Brief    : N*N x DW register array, sync write, registered read, sync reset.
// Revision : 1.0
// ============================================================================
module jam_cost_mem
    import jam_pkg::*;
(
    input  wire logic            CLK,
    input  wire logic            RST,
    input  wire logic            we,
    input  wire logic [CNTW-1:0] waddr,
    input  wire cost_t           wdata,
    input  wire logic [CNTW-1:0] raddr,
    output      cost_t           rdata
);
    cost_t mem_q [DEPTH];
    cost_t mem_d [DEPTH];
    cost_t rdata_q;
    cost_t rdata_d;

    // Read uses mem_q, so a same-cycle write to the read address returns the old entry.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
        rdata_d = mem_q[raddr];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_q   <= '{default: '0};
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule
`default_nettype wire

// File: rtl/jam_cost_table.sv
`default_nettype none
// ============================================================================
// Module   : jam_cost_table
// Brief    : Serially loaded 8x8 cost table with 1-cycle (W,J) lookup.
//            Optional running checksum of loaded entries: JAM_COST_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module jam_cost_table
    import jam_pkg::*;
(
    input  wire logic        CLK,
    input  wire logic        RST,
    jam_cost_table_if.slave  bus
);
    jam_tbl_state_t   state_q;
    jam_tbl_state_t   state_d;
    logic [CNTW-1:0]  load_cnt_q;
    logic [CNTW-1:0]  load_cnt_d;
    logic             w_in_ready;
    logic             w_beat;

    assign w_in_ready    = (state_q == LOAD);
    assign bus.in_ready  = w_in_ready;
    assign bus.tbl_ready = (state_q == READY);

    // reload wins over a coincident beat; that beat is dropped entirely.
    assign w_beat = bus.in_valid & w_in_ready & ~bus.reload;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        if (bus.reload) begin
            state_d    = LOAD;
            load_cnt_d = '0;
        end else if (w_beat) begin
            load_cnt_d = load_cnt_q + 1'b1;
            if (load_cnt_q == CNTW'(DEPTH - 1)) begin
                state_d = READY;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= LOAD;
            load_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
        end
    end

`ifdef JAM_COST_CHECKSUM_EN
    logic [CW-1:0] checksum_q;
    logic [CW-1:0] checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (bus.reload) begin
            checksum_d = '0;
        end else if (w_beat) begin
            checksum_d = checksum_q + CW'(bus.in_data);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign bus.checksum = checksum_q;
`else
    assign bus.checksum = '0;
`endif

    jam_cost_mem u_mem (
        .CLK   (CLK),
        .RST   (RST),
        .we    (w_beat),
        .waddr (load_cnt_q),
        .wdata (bus.in_data),
        .raddr ({bus.W, bus.J}),
        .rdata (bus.Cost)
    );
endmodule
`default_nettype wire

// File: tb/tb_jam_cost_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_jam_cost_table
// Brief    : Directed bench with lookup scoreboard for jam_cost_table.
// Revision : 1.0
// ============================================================================
module tb_jam_cost_table;
    import jam_pkg::*;

`ifdef JAM_COST_CHECKSUM_EN
    localparam bit CS_ON = 1'b1;
`else
    localparam bit CS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jam_cost_table_if bus ();

    jam_cost_table dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int    checks = 0;
    int    errors = 0;
    cost_t sb_q [$];
    cost_t model [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cs_exp(input int sum);
        return CS_ON ? 32'(sum) : 32'd0;
    endfunction

    function automatic cost_t data_of(input int mode, input int k);
        case (mode)
            0:       return cost_t'(k % 128);
            1:       return cost_t'((k * 2) % 128);
            2:       return cost_t'(9);
            3:       return cost_t'(127);
            4:       return cost_t'(k + 1);
            default: return cost_t'(k + 3);
        endcase
    endfunction

    // One clock; any pending lookup expectation is resolved right after the edge.
    task automatic tick();
        cost_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("cost_lookup", 32'(bus.Cost), 32'(e));
        end
    endtask

    task automatic lookup(input int w, input int j);
        bus.W = AW'(w);
        bus.J = AW'(j);
        sb_q.push_back(model[w * N + j]);
        tick();
    endtask

    task automatic pulse_reload();
        bus.reload = 1'b1;
        tick();
        bus.reload = 1'b0;
    endtask

    task automatic load(input int mode, input int duty, input int nbeats, output int cycles);
        int  k;
        logic beat;
        k      = 0;
        cycles = 0;
        while (k < nbeats && cycles < 2000) begin
            bus.in_valid = ($urandom_range(99) < duty);
            bus.in_data  = data_of(mode, k);
            beat = bus.in_valid && bus.in_ready;
            if (beat && k == DEPTH - 1) begin
                chk("tbl_ready_before_last", 32'(bus.tbl_ready), 32'd0);
            end
            tick();
            cycles++;
            if (beat) begin
                model[k] = data_of(mode, k);
                k++;
            end
        end
        bus.in_valid = 1'b0;
        if (k != nbeats) begin
            chk("load_timeout", 32'(k), 32'(nbeats));
        end
        chk("tbl_ready_after_load", 32'(bus.tbl_ready), (nbeats == DEPTH) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.reload   = 1'b0;
        bus.W        = '0;
        bus.J        = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_tbl_ready", 32'(bus.tbl_ready), 32'd0);
        chk("reset_cost",      32'(bus.Cost),      32'd0);
        chk("reset_checksum",  32'(bus.checksum),  32'd0);
        chk("reset_in_ready",  32'(bus.in_ready),  32'd1);

        // Test 1: continuous load of k%128
        load(0, 100, DEPTH, cyc);
        chk("t1_cycles", 32'(cyc), 32'd64);
        chk("t1_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("t1_checksum", 32'(bus.checksum), cs_exp(2016));
        lookup(5, 3);

        // Test 2: gappy load of k*2, then stray in_valid in READY
        pulse_reload();
        chk("t2_reload_ready", 32'(bus.tbl_ready), 32'd0);
        load(1, 50, DEPTH, cyc);
        lookup(7, 7);
        bus.in_valid = 1'b1;
        bus.in_data  = '0;
        for (int i = 0; i < 5; i++) tick();
        bus.in_valid = 1'b0;
        chk("t2_in_ready_ready", 32'(bus.in_ready), 32'd0);
        chk("t2_tbl_ready_hold", 32'(bus.tbl_ready), 32'd1);
        chk("t2_checksum", 32'(bus.checksum), cs_exp(4032));
        lookup(7, 7);
        lookup(0, 1);

        // Test 3: abort after 20 beats, then full reload of 9
        pulse_reload();
        load(4, 100, 20, cyc);
        pulse_reload();
        chk("t3_after_reload", 32'(bus.tbl_ready), 32'd0);
        load(2, 100, DEPTH, cyc);
        chk("t3_checksum", 32'(bus.checksum), cs_exp(576));
        for (int i = 0; i < DEPTH; i++) lookup(i / N, i % N);

        // Test 4: reload coincident with beat 63
        pulse_reload();
        load(4, 100, DEPTH - 1, cyc);
        bus.in_valid = 1'b1;
        bus.in_data  = cost_t'(100);
        bus.reload   = 1'b1;
        tick();
        bus.reload   = 1'b0;
        bus.in_valid = 1'b0;
        chk("t4_no_ready", 32'(bus.tbl_ready), 32'd0);
        chk("t4_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t4_checksum", 32'(bus.checksum), 32'd0);
        // load_cnt restarted: the next beat lands in entry 0 while entry 0 is read (old value)
        bus.W = '0;
        bus.J = '0;
        sb_q.push_back(model[0]);
        bus.in_valid = 1'b1;
        bus.in_data  = cost_t'(77);
        tick();
        bus.in_valid = 1'b0;
        model[0] = cost_t'(77);
        lookup(0, 0);
        lookup(7, 7);
        lookup(0, 1);
        chk("t4_still_loading", 32'(bus.tbl_ready), 32'd0);

        // Test 5: reset in the middle of a load
        pulse_reload();
        load(5, 100, 30, cyc);
        bus.in_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("t5_tbl_ready", 32'(bus.tbl_ready), 32'd0);
        chk("t5_cost",      32'(bus.Cost),      32'd0);
        chk("t5_checksum",  32'(bus.checksum),  32'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int i = 0; i < DEPTH; i++) lookup(i / N, i % N);

        // Test 6: max-valued table for the checksum
        load(3, 100, DEPTH, cyc);
        chk("t6_checksum_full", 32'(bus.checksum), cs_exp(8128));
        lookup(4, 6);
        pulse_reload();
        chk("t6_checksum_clr", 32'(bus.checksum), 32'd0);
        chk("t6_tbl_ready", 32'(bus.tbl_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
